cache_refill_arbiter: RTL and testbench

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

---
 rtl/cache_refill_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_refill_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_arbiter.sv
// Two-client (I-cache / D-cache) refill arbiter sharing one memory line port.
// Optional round-robin arbitration when REFILL_ARB_RR_EN is defined; fixed I-cache priority otherwise.
module cache_refill_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ic_req,
   input  logic [31:0]  ic_addr,
   output logic         ic_addr_ok,
   output logic         ic_data_ok,
   input  logic         dc_req,
   input  logic [31:0]  dc_addr,
   output logic         dc_addr_ok,
   output logic         dc_data_ok,
   output logic [255:0] rdata,
   output logic         mem_req,
   output logic [31:0]  mem_addr,
   input  logic         mem_addr_ok,
   input  logic         mem_data_ok,
   input  logic [255:0] mem_rdata,
   output logic         busy,
   output logic         timeout
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_e;

   // Abort fires on the DATA cycle that would bring the counter to TIMEOUT_CYCLES.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        grant_dc_q, grant_dc_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        pick_dc;

`ifdef REFILL_ARB_RR_EN
   logic        last_dc_q, last_dc_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_dc_q <= 1'b1;
      end else begin
         last_dc_q <= last_dc_d;
      end
   end

   assign pick_dc = dc_req && (!ic_req || !last_dc_q);
`else
   assign pick_dc = dc_req && !ic_req;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         grant_dc_q <= 1'b0;
         addr_q     <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_dc_q <= grant_dc_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_dc_d = grant_dc_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
`ifdef REFILL_ARB_RR_EN
      last_dc_d  = last_dc_q;
`endif
      mem_req    = 1'b0;
      ic_addr_ok = 1'b0;
      dc_addr_ok = 1'b0;
      ic_data_ok = 1'b0;
      dc_data_ok = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ic_req || dc_req) begin
               grant_dc_d = pick_dc;
               addr_d     = (pick_dc ? dc_addr : ic_addr) & ~32'h0000_001F;
               state_d    = ADDR;
`ifdef REFILL_ARB_RR_EN
               last_dc_d  = pick_dc;
`endif
            end
         end
         ADDR: begin
            mem_req = 1'b1;
            if (mem_addr_ok) begin
               ic_addr_ok = !grant_dc_q;
               dc_addr_ok = grant_dc_q;
               cnt_d      = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (mem_data_ok) begin
               ic_data_ok = !grant_dc_q;
               dc_data_ok = grant_dc_q;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == CNT_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr = addr_q;
   assign rdata    = mem_rdata;
   assign busy     = (state_q != IDLE);
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed table-driven bench for cache_refill_arbiter (TIMEOUT_CYCLES=4), plus a hand-written timeout sequence.
module tb_cache_refill_arbiter;

`ifdef REFILL_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam logic [31:0] IC_A   = 32'h0000_1234;
   localparam logic [31:0] DC_A   = 32'hDEAD_BEEF;
   localparam logic [31:0] IC_LA  = 32'h0000_1220;
   localparam logic [31:0] DC_LA  = 32'hDEAD_BEE0;

   // flags = {ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok, mem_req, busy, timeout}
   localparam logic [6:0] E_IDLE = 7'b0000_000;
   localparam logic [6:0] E_ADDR = 7'b0000_110;
   localparam logic [6:0] E_DATA = 7'b0000_010;
   localparam logic [6:0] E_IAOK = 7'b1000_110;
   localparam logic [6:0] E_IDOK = 7'b0100_010;
   localparam logic [6:0] E_DAOK = 7'b0010_110;
   localparam logic [6:0] E_DDOK = 7'b0001_010;

   typedef struct {
      string       name;
      logic        rstn;
      logic        ic;
      logic        dc;
      logic        aok;
      logic        dok;
      logic [6:0]  exp;
      logic [31:0] exp_addr;
   } vec_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic         ic_req, dc_req, mem_addr_ok, mem_data_ok;
   logic [31:0]  ic_addr, dc_addr, mem_addr;
   logic         ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok;
   logic         mem_req, busy, timeout;
   logic [255:0] rdata, mem_rdata;

   int unsigned applied = 0;
   int unsigned miscompares = 0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   cache_refill_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ic_req     (ic_req),
      .ic_addr    (ic_addr),
      .ic_addr_ok (ic_addr_ok),
      .ic_data_ok (ic_data_ok),
      .dc_req     (dc_req),
      .dc_addr    (dc_addr),
      .dc_addr_ok (dc_addr_ok),
      .dc_data_ok (dc_data_ok),
      .rdata      (rdata),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .timeout    (timeout)
   );

   function automatic vec_t mk(string n, logic r, logic i, logic d, logic a, logic o,
                               logic [6:0] e, logic [31:0] ea);
      vec_t v;
      v.name = n; v.rstn = r; v.ic = i; v.dc = d; v.aok = a; v.dok = o;
      v.exp = e; v.exp_addr = ea;
      return v;
   endfunction

   function automatic logic [6:0] flags();
      return {ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok, mem_req, busy, timeout};
   endfunction

   // Drive on the falling edge, check 1ns later, state advances on the next rising edge.
   task automatic apply(input vec_t v);
      logic [255:0] want_rd;
      logic         bad;
      @(negedge clk);
      resetn      = v.rstn;
      ic_req      = v.ic;
      dc_req      = v.dc;
      mem_addr_ok = v.aok;
      mem_data_ok = v.dok;
      want_rd     = {8{32'hC0DE_0000 | 32'(applied)}};
      mem_rdata   = want_rd;
      #1;
      applied++;
      bad = (flags() !== v.exp) || (rdata !== want_rd) ||
            ((v.exp_addr != 32'd0) && (mem_addr !== v.exp_addr));
      if (bad) begin
         miscompares++;
         $display("FAIL %s: got flags=%b addr=%h rd_ok=%0d, want flags=%b addr=%h",
                  v.name, flags(), mem_addr, rdata === want_rd, v.exp, v.exp_addr);
      end
   endtask

   task automatic check(input string n, input logic ok, input int got, input int want);
      applied++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", n, got, want);
      end
   endtask

   initial begin
      int unsigned data_cycles;
      logic        saw_bad;
      logic        to_seen;

      resetn = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      ic_addr = IC_A; dc_addr = DC_A; mem_rdata = '0;
      repeat (2) @(posedge clk);

      vecs.push_back(mk("rst",            0,0,0,0,0, E_IDLE, 0));
      vecs.push_back(mk("idle_ign_oks",   1,0,0,1,1, E_IDLE, 0));
      vecs.push_back(mk("idle_quiet",     1,0,0,0,0, E_IDLE, 0));
      // basic I-cache refill
      vecs.push_back(mk("ic_req",         1,1,0,0,0, E_IDLE, 0));
      vecs.push_back(mk("ic_addr_wait",   1,1,0,0,0, E_ADDR, IC_LA));
      vecs.push_back(mk("ic_addr_ok",     1,1,0,1,0, E_IAOK, IC_LA));
      vecs.push_back(mk("ic_data_w1",     1,0,0,0,0, E_DATA, 0));
      vecs.push_back(mk("ic_data_w2",     1,0,0,0,0, E_DATA, 0));
      vecs.push_back(mk("ic_data_ok",     1,0,0,0,1, E_IDOK, 0));
      vecs.push_back(mk("ic_done",        1,0,0,0,0, E_IDLE, 0));
      // data_ok during ADDR and addr_ok during DATA are ignored
      vecs.push_back(mk("dc_req",         1,0,1,0,0, E_IDLE, 0));
      vecs.push_back(mk("dc_dok_in_addr", 1,0,1,0,1, E_ADDR, DC_LA));
      vecs.push_back(mk("dc_addr_ok",     1,0,1,1,0, E_DAOK, DC_LA));
      vecs.push_back(mk("dc_aok_in_data", 1,0,0,1,0, E_DATA, 0));
      vecs.push_back(mk("dc_data_ok",     1,0,0,0,1, E_DDOK, 0));
      vecs.push_back(mk("dc_done",        1,0,0,0,0, E_IDLE, 0));
      // data_ok on the last allowed DATA cycle beats the timeout; late dc_req waits
      vecs.push_back(mk("bnd_req",        1,1,0,0,0, E_IDLE, 0));
      vecs.push_back(mk("bnd_addr_ok",    1,1,0,1,0, E_IAOK, IC_LA));
      vecs.push_back(mk("bnd_w1",         1,0,1,0,0, E_DATA, 0));
      vecs.push_back(mk("bnd_w2",         1,0,1,0,0, E_DATA, 0));
      vecs.push_back(mk("bnd_w3",         1,0,1,0,0, E_DATA, 0));
      vecs.push_back(mk("bnd_data_ok",    1,0,1,0,1, E_IDOK, 0));
      vecs.push_back(mk("bnd_no_to",      1,0,1,0,0, E_IDLE, 0));
      vecs.push_back(mk("late_dc_addr",   1,0,1,0,0, E_ADDR, DC_LA));
      // reset in ADDR abandons the transaction
      vecs.push_back(mk("rst_in_addr",    0,0,1,0,0, E_ADDR, DC_LA));
      vecs.push_back(mk("post_rst_aok",   1,0,0,1,0, E_IDLE, 0));
      // reset in DATA, then a stray data_ok
      vecs.push_back(mk("r_req",          1,0,1,0,0, E_IDLE, 0));
      vecs.push_back(mk("r_addr_ok",      1,0,1,1,0, E_DAOK, DC_LA));
      vecs.push_back(mk("r_data",         1,0,0,0,0, E_DATA, 0));
      vecs.push_back(mk("r_rst_in_data",  0,0,0,0,0, E_DATA, 0));
      vecs.push_back(mk("r_late_dok",     1,0,0,0,1, E_IDLE, 0));
      vecs.push_back(mk("r_idle",         1,0,0,0,0, E_IDLE, 0));
      // three back-to-back transactions with both clients requesting
      for (int k = 0; k < 3; k++) begin
         bit g;
         g = RR && (k == 1);
         vecs.push_back(mk($sformatf("arb%0d_idle", k), 1,1,1,0,0, E_IDLE, 0));
         vecs.push_back(mk($sformatf("arb%0d_aok", k),  1,1,1,1,0,
                           g ? E_DAOK : E_IAOK, g ? DC_LA : IC_LA));
         vecs.push_back(mk($sformatf("arb%0d_dok", k),  1,1,1,0,1,
                           g ? E_DDOK : E_IDOK, 0));
      end
      vecs.push_back(mk("arb_end",        1,0,0,0,0, E_IDLE, 0));

      foreach (vecs[i]) apply(vecs[i]);

      // timeout: dc_req held, memory never returns data
      apply(mk("to_req",     1,0,1,0,0, E_IDLE, 0));
      apply(mk("to_addr_ok", 1,0,1,1,0, E_DAOK, DC_LA));
      data_cycles = 0;
      saw_bad     = 1'b0;
      to_seen     = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         dc_req = 1'b1; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
         #1;
         if (!busy) begin
            dc_req  = 1'b0;
            to_seen = timeout;
            break;
         end
         data_cycles++;
         if (dc_data_ok || ic_data_ok || timeout) saw_bad = 1'b1;
      end
      check("to_data_cycles", data_cycles == 4, int'(data_cycles), 4);
      check("to_idle_flag",   to_seen === 1'b1, int'(to_seen), 1);
      check("to_no_data_ok",  saw_bad === 1'b0, int'(saw_bad), 0);
      apply(mk("to_sticky",   1,0,0,0,1, 7'b0000_001, 0));
      apply(mk("to_rst",      0,0,0,0,0, 7'b0000_001, 0));
      apply(mk("to_cleared",  1,0,0,0,0, E_IDLE, 0));

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
